// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transceiver.
//   - parity-mode encodings (PAR_NONE / PAR_EVEN / PAR_ODD)
//   - TX and RX state encodings
//   - par_bit(): parity bit for a payload of up to 9 bits
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // RX_BREAK holds off re-arming after a framing error until the line is high again.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Payloads narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
    function automatic logic par_bit(input logic [8:0] data, input int mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-direction bit timer for the UART.
//   clk, rst_n : clock, async active-low reset
//   start      : reload the counter for the first bit of a frame
//   run        : count while a frame is in progress
//   mid_tick   : high in the mid-bit cycle (RX sample point)
//   end_tick   : high in the last cycle of each bit
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic mid_tick,
    output logic end_tick
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] MID  = TW'(CLKS_PER_BIT / 2);

    logic [TW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= LOAD;
        end else if (run) begin
            cnt <= (cnt == '0) ? LOAD : cnt - 1'b1;
        end
    end

    assign end_tick = run && (cnt == '0);
    assign mid_tick = run && (cnt == MID);

endmodule

// File: rtl/uart_trx_param.sv
// Parametrised full-duplex UART transceiver.
//   clk, rst_n      : clock, async active-low reset
//   tx_en           : transmitter enable
//   tx_valid/ready  : word handshake, tx_in latched on acceptance
//   tx_out          : serial output, idles high
//   tx_busy/tx_done : frame in progress / pulse in last cycle of final stop bit
//   rx_en           : receiver enable, low aborts a frame at once
//   rx_in           : asynchronous serial input
//   rx_out          : last received word, with rx_parity_err / rx_frame_err
//   rx_valid        : one-cycle pulse when rx_out and the flags update
//   rx_busy         : receiver is inside a frame
module uart_trx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_en,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_in,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 rx_en,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_out,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
    localparam bit HAS_PAR = (PARITY != PAR_NONE);

    // ------------------------------------------------------------------ TX
    tx_state_t            tx_state, tx_state_next;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par;
    logic [IW-1:0]        tx_idx;
    logic                 tx_accept, tx_end, tx_mid_unused;

    assign tx_ready  = tx_en && (tx_state == TX_IDLE);
    assign tx_accept = tx_valid && tx_ready;
    assign tx_busy   = (tx_state != TX_IDLE);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tx_accept),
        .run      (tx_busy),
        .mid_tick (tx_mid_unused),
        .end_tick (tx_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_shreg <= '0;
            tx_par   <= 1'b0;
            tx_idx   <= '0;
        end else begin
            tx_state <= tx_state_next;
            if (tx_accept) begin
                tx_shreg <= tx_in;
                tx_par   <= par_bit(9'(tx_in), PARITY);
                tx_idx   <= '0;
            end else if (tx_end && (tx_state == TX_DATA)) begin
                tx_shreg <= tx_shreg >> 1;
                tx_idx   <= (tx_idx == LAST_DATA) ? '0 : tx_idx + 1'b1;
            end else if (tx_end && (tx_state == TX_STOP)) begin
                tx_idx   <= (tx_idx == LAST_STOP) ? '0 : tx_idx + 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        tx_state_next = tx_state;
        tx_out        = 1'b1;
        tx_done       = 1'b0;
        case (tx_state)
            TX_IDLE:   if (tx_accept) tx_state_next = TX_START;
            TX_START: begin
                tx_out = 1'b0;
                if (tx_end) tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                tx_out = tx_shreg[0];
                if (tx_end && (tx_idx == LAST_DATA))
                    tx_state_next = HAS_PAR ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx_out = tx_par;
                if (tx_end) tx_state_next = TX_STOP;
            end
            TX_STOP: begin
                if (tx_end && (tx_idx == LAST_STOP)) begin
                    tx_done       = 1'b1;
                    tx_state_next = TX_IDLE;
                end
            end
            default:   tx_state_next = TX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ RX
    rx_state_t            rx_state, rx_state_next;
    logic [1:0]           rx_sync_q;
    logic                 rx_bit;
    logic [DATA_BITS-1:0] rx_shreg;
    logic [IW-1:0]        rx_idx;
    logic                 rx_perr_q, rx_ferr_q;
    logic                 rx_start, rx_shift, rx_par_chk, rx_stop_chk, rx_finish;
    logic                 rx_run, rx_mid, rx_end_unused;

    assign rx_bit  = rx_sync_q[1];
    assign rx_run  = (rx_state == RX_START) || (rx_state == RX_DATA) ||
                     (rx_state == RX_PARITY) || (rx_state == RX_STOP);
    assign rx_busy = rx_run;

    // Every RX decision (start check and each bit sample) happens on the mid-bit tick.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (rx_start),
        .run      (rx_run),
        .mid_tick (rx_mid),
        .end_tick (rx_end_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchroniser resets to the idle-line level so reset release cannot fake a start bit.
            rx_sync_q     <= 2'b11;
            rx_state      <= RX_IDLE;
            // NOTE: the datapath registers are reset too, so rx_out is defined before the first frame.
            rx_shreg      <= '0;
            rx_idx        <= '0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_out        <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_in};
            rx_state  <= rx_state_next;
            rx_valid  <= rx_finish;
            if (rx_start) begin
                rx_idx    <= '0;
                rx_perr_q <= 1'b0;
                rx_ferr_q <= 1'b0;
            end
            if (rx_shift) begin
                rx_shreg <= {rx_bit, rx_shreg[DATA_BITS-1:1]};
                rx_idx   <= (rx_idx == LAST_DATA) ? '0 : rx_idx + 1'b1;
            end
            if (rx_par_chk)
                rx_perr_q <= (rx_bit != par_bit(9'(rx_shreg), PARITY));
            if (rx_stop_chk) begin
                rx_ferr_q <= rx_ferr_q | ~rx_bit;
                rx_idx    <= (rx_idx == LAST_STOP) ? '0 : rx_idx + 1'b1;
            end
            // The final stop sample is folded in directly since rx_ferr_q has not seen it yet.
            if (rx_finish) begin
                rx_out        <= rx_shreg;
                rx_parity_err <= rx_perr_q;
                rx_frame_err  <= rx_ferr_q | ~rx_bit;
            end
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_start      = 1'b0;
        rx_shift      = 1'b0;
        rx_par_chk    = 1'b0;
        rx_stop_chk   = 1'b0;
        rx_finish     = 1'b0;
        if (!rx_en) begin
            rx_state_next = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_bit) begin
                        rx_start      = 1'b1;
                        rx_state_next = RX_START;
                    end
                end
                RX_START:  if (rx_mid) rx_state_next = rx_bit ? RX_IDLE : RX_DATA;
                RX_DATA: begin
                    if (rx_mid) begin
                        rx_shift = 1'b1;
                        if (rx_idx == LAST_DATA)
                            rx_state_next = HAS_PAR ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: begin
                    if (rx_mid) begin
                        rx_par_chk    = 1'b1;
                        rx_state_next = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_mid) begin
                        rx_stop_chk = 1'b1;
                        if (rx_idx == LAST_STOP) begin
                            rx_finish     = 1'b1;
                            rx_state_next = (rx_ferr_q || !rx_bit) ? RX_BREAK : RX_IDLE;
                        end
                    end
                end
                RX_BREAK:  if (rx_bit) rx_state_next = RX_IDLE;
                default:   rx_state_next = RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_trx_param.sv
// Self-checking bench for uart_trx_param: a default instance (8N1) and an
// even-parity instance, each either looped back or driven by hand on rx_in.
// Expected received words are queued when a frame is launched and compared
// when rx_valid pulses.
module tb_uart_trx_param;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic man_rx;

    logic       d_tx_en, d_tx_valid, d_tx_ready, d_tx_out, d_tx_busy, d_tx_done;
    logic [7:0] d_tx_in, d_rx_out;
    logic       d_rx_en, d_rx_in, d_rx_valid, d_rx_busy, d_rx_parity_err, d_rx_frame_err, d_sel;

    logic       p_tx_en, p_tx_valid, p_tx_ready, p_tx_out, p_tx_busy, p_tx_done;
    logic [7:0] p_tx_in, p_rx_out;
    logic       p_rx_en, p_rx_in, p_rx_valid, p_rx_busy, p_rx_parity_err, p_rx_frame_err, p_sel;

    int   checks   = 0;
    int   failures = 0;
    exp_t d_q[$];
    exp_t p_q[$];

    always #5 clk = ~clk;

    assign d_rx_in = d_sel ? man_rx : d_tx_out;
    assign p_rx_in = p_sel ? man_rx : p_tx_out;

    uart_trx_param u_dut (
        .clk(clk), .rst_n(rst_n),
        .tx_en(d_tx_en), .tx_valid(d_tx_valid), .tx_ready(d_tx_ready), .tx_in(d_tx_in),
        .tx_out(d_tx_out), .tx_busy(d_tx_busy), .tx_done(d_tx_done),
        .rx_en(d_rx_en), .rx_in(d_rx_in), .rx_out(d_rx_out), .rx_valid(d_rx_valid),
        .rx_busy(d_rx_busy), .rx_parity_err(d_rx_parity_err), .rx_frame_err(d_rx_frame_err)
    );

    uart_trx_param #(.PARITY(1)) u_par (
        .clk(clk), .rst_n(rst_n),
        .tx_en(p_tx_en), .tx_valid(p_tx_valid), .tx_ready(p_tx_ready), .tx_in(p_tx_in),
        .tx_out(p_tx_out), .tx_busy(p_tx_busy), .tx_done(p_tx_done),
        .rx_en(p_rx_en), .rx_in(p_rx_in), .rx_out(p_rx_out), .rx_valid(p_rx_valid),
        .rx_busy(p_rx_busy), .rx_parity_err(p_rx_parity_err), .rx_frame_err(p_rx_frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitors: every rx_valid must match the oldest queued word.
    always @(negedge clk) begin : mon_d
        exp_t e;
        if (d_rx_valid) begin
            if (d_q.size() == 0) begin
                check("d_rx_unexpected_valid", 1, 0);
            end else begin
                e = d_q.pop_front();
                check("d_rx_out", d_rx_out, e.data);
                check("d_rx_parity_err", d_rx_parity_err, e.perr);
                check("d_rx_frame_err", d_rx_frame_err, e.ferr);
            end
        end
    end

    always @(negedge clk) begin : mon_p
        exp_t e;
        if (p_rx_valid) begin
            if (p_q.size() == 0) begin
                check("p_rx_unexpected_valid", 1, 0);
            end else begin
                e = p_q.pop_front();
                check("p_rx_out", p_rx_out, e.data);
                check("p_rx_parity_err", p_rx_parity_err, e.perr);
                check("p_rx_frame_err", p_rx_frame_err, e.ferr);
            end
        end
    end

    task automatic push_exp(input bit use_par, input logic [7:0] data, input logic perr, input logic ferr);
        exp_t e;
        e.data = data; e.perr = perr; e.ferr = ferr;
        if (use_par) p_q.push_back(e); else d_q.push_back(e);
    endtask

    task automatic wait_tx_ready(input bit use_par);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (use_par ? p_tx_ready : d_tx_ready) ok = 1'b1;
        end
        check("tx_ready_wait", ok, 1);
    endtask

    task automatic wait_drain(input bit use_par);
        int sz = 1;
        for (int i = 0; i < 400 && sz != 0; i++) begin
            @(negedge clk);
            sz = use_par ? p_q.size() : d_q.size();
        end
        check(use_par ? "p_scoreboard_drain" : "d_scoreboard_drain", sz, 0);
    endtask

    // Launch one word on the chosen instance and time tx_done from acceptance.
    task automatic send_frame(input bit use_par, input logic [7:0] data, input int lat);
        int n = 0;
        bit seen = 1'b0;
        @(posedge clk); #1;
        if (use_par) begin p_tx_in = data; p_tx_valid = 1'b1; end
        else         begin d_tx_in = data; d_tx_valid = 1'b1; end
        wait_tx_ready(use_par);
        @(posedge clk); #1;
        p_tx_valid = 1'b0;
        d_tx_valid = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("tx_start_low", use_par ? p_tx_out : d_tx_out, 0);
                check("tx_busy_first", use_par ? p_tx_busy : d_tx_busy, 1);
            end
            if (use_par && n == 9 * CPB + CPB / 2)
                check("tx_parity_bit", p_tx_out, {31'b0, ^data});
            if (use_par ? p_tx_done : d_tx_done) seen = 1'b1;
        end
        check("tx_done_latency", n, lat);
        @(negedge clk);
        check("tx_ready_after_done", use_par ? p_tx_ready : d_tx_ready, 1);
    endtask

    // Drive nbits on man_rx, LSB first, each CPB cycles long.
    task automatic serial(input logic [15:0] bits, input int nbits);
        @(posedge clk); #1;
        for (int i = 0; i < nbits; i++) begin
            man_rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cnt;
        int idle;
        int vcnt;
        bit seen;

        rst_n = 1'b0; man_rx = 1'b1; d_sel = 1'b0; p_sel = 1'b0;
        d_tx_en = 1'b0; d_tx_valid = 1'b0; d_tx_in = '0; d_rx_en = 1'b0;
        p_tx_en = 1'b0; p_tx_valid = 1'b0; p_tx_in = '0; p_rx_en = 1'b0;
        #1;
        check("rst_tx_out", d_tx_out, 1);
        check("rst_tx_busy", d_tx_busy, 0);
        check("rst_tx_done", d_tx_done, 0);
        check("rst_tx_ready", d_tx_ready, 0);
        check("rst_rx_out", d_rx_out, 0);
        check("rst_rx_valid", d_rx_valid, 0);
        check("rst_rx_busy", d_rx_busy, 0);
        check("rst_rx_errs", {d_rx_parity_err, d_rx_frame_err}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        d_rx_en = 1'b1; p_rx_en = 1'b1; p_tx_en = 1'b1;

        // tx_valid with tx_en low is ignored.
        d_tx_in = 8'h11; d_tx_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d_tx_busy || d_tx_ready) cnt++;
        end
        check("tx_en_low_ignored", cnt, 0);
        @(posedge clk); #1 d_tx_valid = 1'b0; d_tx_en = 1'b1;

        // Default loopback.
        push_exp(0, 8'hA5, 0, 0);
        send_frame(0, 8'hA5, 10 * CPB);
        wait_drain(0);

        // Even-parity loopback, then a hand-driven frame with the parity bit flipped.
        push_exp(1, 8'h07, 0, 0);
        send_frame(1, 8'h07, 11 * CPB);
        wait_drain(1);
        p_sel = 1'b1;
        push_exp(1, 8'h07, 1, 0);
        serial({5'b0, 1'b1, ~(^8'h07), 8'h07, 1'b0}, 11);
        man_rx = 1'b1;
        wait_drain(1);
        p_sel = 1'b0;

        // Framing error: stop bit low, line kept low, receiver must stay disarmed.
        d_sel = 1'b1;
        push_exp(0, 8'h3C, 0, 1);
        serial({6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (d_rx_busy) cnt++;
        end
        check("break_no_rearm", cnt, 0);
        wait_drain(0);
        @(posedge clk); #1 man_rx = 1'b1;
        repeat (20) @(posedge clk);
        push_exp(0, 8'h81, 0, 0);
        serial({6'b0, 1'b1, 8'h81, 1'b0}, 10);
        man_rx = 1'b1;
        wait_drain(0);

        // 3-cycle start glitch.
        repeat (20) @(posedge clk);
        #1 man_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 man_rx = 1'b1;
        cnt = 0; vcnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (d_rx_busy) cnt++;
            if (d_rx_valid) vcnt++;
        end
        check("glitch_busy_cycles", cnt, CPB / 2);
        check("glitch_no_valid", vcnt, 0);
        check("glitch_busy_end", d_rx_busy, 0);
        d_sel = 1'b0;

        // Back-to-back frames with tx_valid held high.
        push_exp(0, 8'h00, 0, 0);
        push_exp(0, 8'hFF, 0, 0);
        @(posedge clk); #1 d_tx_in = 8'h00; d_tx_valid = 1'b1;
        wait_tx_ready(0);
        @(posedge clk); #1 d_tx_in = 8'hFF;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (d_tx_done) seen = 1'b1;
        end
        check("b2b_first_done", seen, 1);
        idle = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (d_tx_busy) seen = 1'b1; else idle++;
        end
        check("b2b_idle_cycles", idle, 1);
        @(posedge clk); #1 d_tx_valid = 1'b0;
        wait_drain(0);

        // Reset during data bit 3 of a TX frame.
        @(posedge clk); #1 d_tx_in = 8'hC3; d_tx_valid = 1'b1;
        wait_tx_ready(0);
        @(posedge clk); #1 d_tx_valid = 1'b0;
        repeat (4 * CPB + 6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_out", d_tx_out, 1);
        check("mid_rst_tx_busy", d_tx_busy, 0);
        check("mid_rst_tx_done", d_tx_done, 0);
        check("mid_rst_rx_busy", d_rx_busy, 0);
        check("mid_rst_rx_out", d_rx_out, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        push_exp(0, 8'h5A, 0, 0);
        send_frame(0, 8'h5A, 10 * CPB);
        wait_drain(0);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_trx_param.md
Name: uart_trx_param

Overview:
Parametrised full-duplex UART transceiver that supersedes the fixed 8-bit uart_tx/uart_rx pair. It supports configurable data width, an optional parity bit and 1 or 2 stop bits. Bit timing comes from an internal clocks-per-bit divider. TX takes data through a valid/ready handshake. RX samples each bit at mid-bit, rejects start-bit glitches, and reports parity and framing errors. It sits between the system-side byte interface and the serial pins. For loopback benches, tx_out connects directly to rx_in.

Parameters:
DATA_BITS, 8, payload bits per frame; legal range 5..9
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 4 and even
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; 1 or 2

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
tx_en  in  1  transmitter enable
tx_valid  in  1  tx_in holds a word to send
tx_ready  out  1  transmitter can accept a word this cycle
tx_in  in  DATA_BITS  word to transmit
tx_out  out  1  serial output; idles high
tx_busy  out  1  a frame is in progress
tx_done  out  1  one-cycle pulse when the final stop bit ends
rx_en  in  1  receiver enable
rx_in  in  1  serial input; asynchronous to clk
rx_out  out  DATA_BITS  last received word
rx_valid  out  1  one-cycle pulse; rx_out and the error flags are updated
rx_busy  out  1  receiver is inside a frame
rx_parity_err  out  1  parity mismatch in the last frame
rx_frame_err  out  1  a stop bit was sampled low in the last frame

Behaviour:
- Reset (async assert, sync release): tx_out=1; rx_out=0; all other outputs 0; both FSMs go to IDLE; the RX synchroniser flops are set to 1.
- Frame format: start(0), then DATA_BITS bits LSB first, then the parity bit if PARITY!=0, then STOP_BITS ones. Frame length is FRAME = 1+DATA_BITS+(PARITY!=0)+STOP_BITS bits.
- Even parity: the parity bit is the XOR of the data bits. Odd parity: the parity bit is the inverse of that XOR.
- TX FSM states: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- TX handshake:
  - tx_ready = tx_en && state==IDLE.
  - A word is accepted on a cycle where tx_valid && tx_ready; tx_in is latched on that edge.
  - tx_out goes low on the next cycle.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - tx_busy is high from the cycle after acceptance until the cycle tx_done pulses (inclusive).
  - tx_done pulses in the last cycle of the final stop bit. In that same cycle the FSM returns to IDLE, so tx_ready is high on the next cycle.
  - With tx_valid held high, frames are back-to-back with one idle-high cycle between them.
- tx_en deasserted mid-frame: the current frame completes and no further word is accepted.
- RX synchroniser: rx_in passes through 2 flops. All decisions use the synchronised bit.
- RX FSM states: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- IDLE: a sync bit of 0 with rx_en=1 enters START and sets rx_busy.
- START: after CLKS_PER_BIT/2 cycles the line is resampled.
  - If it is 1, this is a glitch: return to IDLE with no flags and no rx_valid.
  - If it is 0, enter DATA.
- DATA, PARITY, STOP: sample every CLKS_PER_BIT cycles, i.e. at mid-bit.
  - In DATA, shift samples in LSB first.
  - In PARITY, compare the sample against the expected value.
  - In STOP, sample each of the STOP_BITS stop bits.
- Frame completion: the cycle after the last stop-bit sample:
  - rx_valid pulses for 1 cycle;
  - rx_out, rx_parity_err and rx_frame_err update together and then hold until the next rx_valid;
  - rx_busy drops.
- A frame with errors still delivers its data, with the error flags set.
- After rx_frame_err, the receiver waits for the sync line to be 1 before re-arming (break handling).
- rx_en deasserted mid-frame: abort to IDLE at once; rx_valid does not pulse and the previous outputs are held.
- Counters: bit-timer width is $clog2(CLKS_PER_BIT); bit-index width is $clog2(DATA_BITS+1). Each counter wraps to 0 at bit end, never by overflow.
- tx_en and rx_en are independent. tx_valid while tx_en=0 is ignored.

Decomposition:
- Shared package uart_pkg contains:
  - the parity-mode localparams PAR_NONE, PAR_EVEN, PAR_ODD;
  - the TX and RX state enums;
  - a function par_bit(data, mode).
- One sub-module: uart_bit_timer, a per-direction down-counter with a start strobe, a mid-bit tick (RX) and an end-of-bit tick. It is instantiated once for TX and once for RX.

Test Plan:
- Defaults, loopback, send 8'hA5 → tx_done pulses 160 cycles after acceptance; rx_valid then pulses with rx_out=8'hA5 and both error flags 0.
- PARITY=1, loopback, send 8'h07 → parity bit on the line is 1; rx_out=8'h07 with rx_parity_err=0. Then drive rx_in by hand with the parity bit inverted → rx_valid with rx_parity_err=1.
- Defaults, drive rx_in directly with stop bit = 0, data 8'h3C → rx_valid with rx_out=8'h3C and rx_frame_err=1. No new frame starts until rx_in has returned high.
- Defaults, drive a 3-cycle low glitch on rx_in → rx_busy rises and then falls at the half-bit check; rx_valid stays 0 for 400 cycles.
- tx_valid held high with 8'h00 then 8'hFF → exactly one idle cycle between frames; rx_valid pulses twice, with 8'h00 then 8'hFF.
- Assert rst_n low during the DATA bit 3 of a TX frame → tx_out=1, tx_busy=0 and tx_done=0 immediately. After release, a clean 8'h5A loopback passes.
